nabp_sinogram_addresser_multi: RTL
==================================

NABP_SINOGRAM_ADDRESSER_MULTI -- requirements
Module: nabp_sinogram_addresser_multi

Interface
REQ-001 Parameters SHALL be:
- kNoOfChannels, 2, number of filtered-RAM channels served.
- kAngleLength, 9, angle width.
- kSLength, 9, projection sample index width.
- kSinogramAddressLength, 17, sinogram address width.
- kNoOfAngles, 180, maximum angles per scan.
- kProjectionLineSize, 256, sinogram words per angle.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- hs_kick  in  1  start scan.
- hs_angle_step  in  kAngleLength  angle increment, latched at kick.
- hs_angle_count  in  kAngleLength  angles to issue, latched at kick.
- hs_base_addr  in  kSinogramAddressLength  sinogram base, latched at kick.
- hs_done  out  1  one-cycle scan-complete pulse.
- fr_next_angle  in  kNoOfChannels  per-channel request for the next angle; also signals the previous angle is finished.
- fr_s_val  in  kNoOfChannels*kSLength  per-channel sample index, channel c at bits [c*kSLength +: kSLength].
- fr_angle  out  kNoOfChannels*kAngleLength  per-channel current angle, registered.
- fr_has_next_angle  out  kNoOfChannels  unissued angles remain.
- fr_next_angle_ack  out  kNoOfChannels  one-hot grant pulse.
- sg_addr  out  kNoOfChannels*kSinogramAddressLength  per-channel sinogram address, registered.

Function
REQ-003 The FSM SHALL have exactly three states: READY, WORK and DRAIN.
REQ-004 READY->WORK SHALL occur on hs_kick, latching step, count and base; the issue counter, next_angle and next_base SHALL be set to 0, 0 and hs_base_addr respectively.
REQ-005 hs_kick SHALL be ignored in WORK and DRAIN.
REQ-006 In WORK, fr_has_next_angle SHALL be all ones while the issue counter < latched count; in READY and DRAIN it SHALL be all zeros.
REQ-007 In WORK with angles remaining, fr_next_angle_ack SHALL grant at most one channel per cycle, the lowest-indexed requester, combinationally in the request cycle.
REQ-008 On a grant to channel c:
- fr_angle[c] <= next_angle and base[c] <= next_base on the next edge.
- next_angle SHALL increment by step; next_base SHALL increment by kProjectionLineSize.
- The issue counter SHALL increment.
REQ-009 Angle and address arithmetic SHALL be modulo 2^width: silent truncation, no saturation.
REQ-010 sg_addr[c] SHALL be registered as base[c] + zero-extended fr_s_val[c], giving 1-cycle latency and updating every cycle regardless of state.
REQ-011 Per-channel busy[c] SHALL be set on grant and cleared when fr_next_angle[c] is high without a grant to channel c.
REQ-012 WORK->DRAIN SHALL occur on the edge at which the issue counter reaches the latched count.
REQ-013 DRAIN->READY SHALL occur when busy == 0, with hs_done high for exactly that cycle.
REQ-014 A latched count of 0 SHALL go WORK->DRAIN on the next edge with no grants, then assert hs_done.
REQ-015 A latched count greater than kNoOfAngles SHALL be clamped to kNoOfAngles.
REQ-016 A step of 0 SHALL be legal, repeating angle 0 with advancing base.
REQ-017 Requests outside WORK SHALL never be acknowledged.

Reset
REQ-018 Asserting reset at any time, including mid-scan, SHALL asynchronously force state READY and clear all outputs, counters, busy bits and registered fr_angle/sg_addr to 0.
REQ-019 The first edge after reset release SHALL accept hs_kick.

Structure
REQ-020 The state encoding, kNoOfAngles and kProjectionLineSize defaults SHALL reside in the shared nabp package.
REQ-021 A sub-module nabp_priority_grant, lowest-index one-hot arbiter parametrised by kNoOfChannels, SHALL be instantiated.

Verification
REQ-022 C=2, step=1, count=4, base=0, both channels requesting continuously -> acks ch0,ch1,ch0,ch1 on consecutive cycles; fr_angle 0,1,2,3; bases 0,256,512,768.
REQ-023 count=0 kick -> no acks, hs_done pulses 2 cycles after kick.
REQ-024 ch1 holds angle 179 in DRAIN, ch0 idle -> hs_done only the cycle after ch1 raises fr_next_angle.
REQ-025 fr_s_val[0]=5, base[0]=512 -> sg_addr[0]=517 one cycle later.
REQ-026 reset asserted mid-WORK at issue count 3 -> all outputs 0 immediately; a new kick restarts from angle 0.
REQ-027 count=300 -> exactly 180 acks, then hs_done.

Source files
------------

// File: rtl/nabp_pkg.sv
// Shared NABP definitions: addresser FSM state encoding and scan geometry defaults.
package nabp_pkg;

    typedef enum logic [1:0] {
        READY = 2'd0,
        WORK  = 2'd1,
        DRAIN = 2'd2
    } nabp_state_e;

    localparam int kDefaultNoOfAngles         = 180;
    localparam int kDefaultProjectionLineSize = 256;

endpackage

// File: rtl/nabp_priority_grant.sv
// Lowest-index-wins one-hot arbiter over a request vector.
module nabp_priority_grant #(
    parameter int kNoOfChannels = 2
) (
    input  logic [kNoOfChannels-1:0] req,
    output logic [kNoOfChannels-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < kNoOfChannels; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nabp_sinogram_addresser_multi.sv
// Hands out successive projection angles to filtered-RAM channels and
// turns each channel's sample index into a registered sinogram address.
module nabp_sinogram_addresser_multi
    import nabp_pkg::*;
#(
    parameter int kNoOfChannels          = 2,
    parameter int kAngleLength           = 9,
    parameter int kSLength               = 9,
    parameter int kSinogramAddressLength = 17,
    parameter int kNoOfAngles            = kDefaultNoOfAngles,
    parameter int kProjectionLineSize    = kDefaultProjectionLineSize
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        hs_kick,
    input  logic [kAngleLength-1:0]                     hs_angle_step,
    input  logic [kAngleLength-1:0]                     hs_angle_count,
    input  logic [kSinogramAddressLength-1:0]           hs_base_addr,
    output logic                                        hs_done,
    input  logic [kNoOfChannels-1:0]                    fr_next_angle,
    input  logic [kNoOfChannels*kSLength-1:0]           fr_s_val,
    output logic [kNoOfChannels*kAngleLength-1:0]       fr_angle,
    output logic [kNoOfChannels-1:0]                    fr_has_next_angle,
    output logic [kNoOfChannels-1:0]                    fr_next_angle_ack,
    output logic [kNoOfChannels*kSinogramAddressLength-1:0] sg_addr
);

    localparam int C  = kNoOfChannels;
    localparam int AL = kAngleLength;
    localparam int AW = kSinogramAddressLength;

    localparam logic [AL-1:0] kMaxCount = AL'(kNoOfAngles);
    localparam logic [AW-1:0] kLineStep = AW'(kProjectionLineSize);

    nabp_state_e state_q, state_d;
    logic [AL-1:0] step_q, step_d;
    logic [AL-1:0] count_q, count_d;
    logic [AL-1:0] issued_q, issued_d;
    logic [AL-1:0] next_angle_q, next_angle_d;
    logic [AW-1:0] next_base_q, next_base_d;
    logic [C-1:0] busy_q, busy_d;
    logic [C-1:0] ack_q, ack_d;
    logic [C-1:0][AL-1:0] fr_angle_q, fr_angle_d;
    logic [C-1:0][AW-1:0] base_q, base_d;
    logic [C-1:0][AW-1:0] sg_addr_q, sg_addr_d;

    logic can_issue;
    logic [C-1:0] req_eff;
    logic [C-1:0] grant;

    assign can_issue = (state_q == WORK) && (issued_q < count_q);

    // A request still held in the cycle after its ack is the same request.
    assign req_eff = fr_next_angle & ~ack_q & {C{can_issue}};

    nabp_priority_grant #(
        .kNoOfChannels(C)
    ) u_grant (
        .req(req_eff),
        .gnt(grant)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        count_d      = count_q;
        issued_d     = issued_q;
        next_angle_d = next_angle_q;
        next_base_d  = next_base_q;
        ack_d        = grant;
        busy_d       = busy_q;
        fr_angle_d   = fr_angle_q;
        base_d       = base_q;
        sg_addr_d    = sg_addr_q;

        case (state_q)
            READY: begin
                if (hs_kick) begin
                    state_d      = WORK;
                    step_d       = hs_angle_step;
                    count_d      = (hs_angle_count > kMaxCount) ?
                                   kMaxCount : hs_angle_count;
                    issued_d     = '0;
                    next_angle_d = '0;
                    next_base_d  = hs_base_addr;
                end
            end
            WORK: begin
                if (|grant) begin
                    issued_d     = issued_q + AL'(1);
                    next_angle_d = next_angle_q + step_q;
                    next_base_d  = next_base_q + kLineStep;
                end
                if (issued_d >= count_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (busy_q == '0) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase

        for (int c = 0; c < C; c++) begin
            if (grant[c]) begin
                fr_angle_d[c] = next_angle_q;
                base_d[c]     = next_base_q;
                busy_d[c]     = 1'b1;
            end else if (fr_next_angle[c]) begin
                busy_d[c] = 1'b0;
            end
            sg_addr_d[c] = base_q[c] +
                           AW'(fr_s_val[c*kSLength +: kSLength]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= READY;
            step_q       <= '0;
            count_q      <= '0;
            issued_q     <= '0;
            next_angle_q <= '0;
            next_base_q  <= '0;
            ack_q        <= '0;
            busy_q       <= '0;
            fr_angle_q   <= '0;
            base_q       <= '0;
            sg_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            count_q      <= count_d;
            issued_q     <= issued_d;
            next_angle_q <= next_angle_d;
            next_base_q  <= next_base_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            fr_angle_q   <= fr_angle_d;
            base_q       <= base_d;
            sg_addr_q    <= sg_addr_d;
        end
    end

    assign hs_done           = (state_q == DRAIN) && (busy_q == '0);
    assign fr_has_next_angle = {C{can_issue}};
    assign fr_next_angle_ack = grant;
    assign fr_angle          = fr_angle_q;
    assign sg_addr           = sg_addr_q;

endmodule
